ccc_apb_cfg_master: RTL and testbench

- APB initiator that drives the fabric CCC's 8-bit dynamic-configuration APB port (PSEL/PENABLE/PWRITE/PADDR/PWDATA/PRDATA).
- Lets fabric logic read and rewrite CCC configuration registers at run time.
- After a reconfiguration, waits for the PLL LOCK to re-qualify.
- Sits between the control logic and the CCC instance, clocked by the APB configuration clock.

---
 rtl/ccc_apb_cfg_master.sv | 206 ++++++++++++++++++++
 tb/tb_ccc_apb_cfg_master.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccc_apb_cfg_master.sv
// APB initiator for the CCC dynamic-configuration port, with PLL LOCK re-qualification.
// Optional lock-wait timeout is enabled by defining CCC_LOCK_TIMEOUT_EN.
module ccc_apb_cfg_master #(
  parameter int ADDR_W           = 6,
  parameter int DATA_W           = 8,
  parameter int LOCK_SYNC_STAGES = 2,
  parameter int LOCK_STABLE      = 16,
  parameter int LOCK_TIMEOUT     = 4096
) (
  input  logic              PCLK,
  input  logic              PRESET_N,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              LOCK,
  output logic              lock_ok
);

  localparam int SC_W = $clog2(LOCK_STABLE + 1);

  if (LOCK_SYNC_STAGES < 2 || LOCK_STABLE < 1 || LOCK_TIMEOUT < 1) begin : g_bad_params
    $error("ccc_apb_cfg_master: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_LOCK_WAIT,
    S_RESP
  } state_t;

  state_t                      state_q, state_d;
  logic                        cmd_ready_q, cmd_ready_d;
  logic                        psel_q, psel_d;
  logic                        penable_q, penable_d;
  logic                        pwrite_q, pwrite_d;
  logic [ADDR_W-1:0]           paddr_q, paddr_d;
  logic [DATA_W-1:0]           pwdata_q, pwdata_d;
  logic                        rsp_valid_q, rsp_valid_d;
  logic                        rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]           rsp_rdata_q, rsp_rdata_d;
  logic [LOCK_SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SC_W-1:0]             stable_cnt_q, stable_cnt_d;
  logic                        lock_qual;

  assign lock_ok   = sync_q[LOCK_SYNC_STAGES-1];
  assign lock_qual = lock_ok && (stable_cnt_q == SC_W'(LOCK_STABLE - 1));
  assign sync_d    = {sync_q[LOCK_SYNC_STAGES-2:0], LOCK};

`ifdef CCC_LOCK_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  logic [TO_W-1:0] timeout_cnt_q, timeout_cnt_d;
  logic            lock_expire;
  assign lock_expire = (timeout_cnt_q == TO_W'(LOCK_TIMEOUT - 1));
`endif

  always_comb begin
    state_d      = state_q;
    psel_d       = psel_q;
    penable_d    = penable_q;
    pwrite_d     = pwrite_q;
    paddr_d      = paddr_q;
    pwdata_d     = pwdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_rdata_d  = rsp_rdata_q;
    stable_cnt_d = stable_cnt_q;
`ifdef CCC_LOCK_TIMEOUT_EN
    timeout_cnt_d = timeout_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            2'b00, 2'b01: begin
              state_d  = S_SETUP;
              psel_d   = 1'b1;
              paddr_d  = cmd_addr;
              pwrite_d = (cmd_op == 2'b00);
              if (cmd_op == 2'b00) pwdata_d = cmd_wdata;
            end
            2'b10: begin
              state_d      = S_LOCK_WAIT;
              stable_cnt_d = '0;
`ifdef CCC_LOCK_TIMEOUT_EN
              timeout_cnt_d = '0;
`endif
            end
            default: begin
              state_d     = S_RESP;
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = '0;
            end
          endcase
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        penable_d = 1'b1;
      end
      // No PREADY on the CCC port: ACCESS always completes in one cycle.
      S_ACCESS: begin
        state_d     = S_RESP;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = pwrite_q ? '0 : PRDATA;
      end
      S_LOCK_WAIT: begin
        if (!lock_ok)
          stable_cnt_d = '0;
        else if (stable_cnt_q != {SC_W{1'b1}})
          stable_cnt_d = stable_cnt_q + SC_W'(1);
`ifdef CCC_LOCK_TIMEOUT_EN
        if (timeout_cnt_q != {TO_W{1'b1}})
          timeout_cnt_d = timeout_cnt_q + TO_W'(1);
`endif
        // Qualification takes priority over a timeout expiring in the same cycle.
        if (lock_qual) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
`ifdef CCC_LOCK_TIMEOUT_EN
        else if (lock_expire) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge PCLK or negedge PRESET_N) begin
    if (!PRESET_N) begin
      state_q      <= S_IDLE;
      cmd_ready_q  <= 1'b1;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      sync_q       <= '0;
      stable_cnt_q <= '0;
`ifdef CCC_LOCK_TIMEOUT_EN
      timeout_cnt_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready_d;
      psel_q       <= psel_d;
      penable_q    <= penable_d;
      pwrite_q     <= pwrite_d;
      paddr_q      <= paddr_d;
      pwdata_q     <= pwdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      sync_q       <= sync_d;
      stable_cnt_q <= stable_cnt_d;
`ifdef CCC_LOCK_TIMEOUT_EN
      timeout_cnt_q <= timeout_cnt_d;
`endif
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Scoreboard bench for ccc_apb_cfg_master: directed timing checks plus randomized commands
// against a register-file reference model.
module tb_ccc_apb_cfg_master;
  localparam int AW = 6, DW = 8, SYNC = 2, STABLE = 16, TMO = 64;

  logic          PCLK = 1'b0;
  logic          PRESET_N;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          PSEL, PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          LOCK, lock_ok;

  logic          man_ready, rnd_ready, rand_mode, init_mem;
  int            errors, checks, cyc, rel_cyc;

  typedef struct packed { logic [DW-1:0] rdata; logic err; } rsp_t;
  rsp_t          exp_q[$];
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] slave_mem [64];
  logic [63:0]   lock_hist;

  always #5 PCLK = ~PCLK;

  assign rsp_ready = rand_mode ? rnd_ready : man_ready;

  ccc_apb_cfg_master #(
    .ADDR_W(AW), .DATA_W(DW), .LOCK_SYNC_STAGES(SYNC), .LOCK_STABLE(STABLE), .LOCK_TIMEOUT(TMO)
  ) dut (
    .PCLK(PCLK), .PRESET_N(PRESET_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .LOCK(LOCK), .lock_ok(lock_ok)
  );

  // CCC register file behind the APB port; PRDATA is junk outside ACCESS.
  assign PRDATA = (PSEL && PENABLE) ? slave_mem[PADDR] : 8'hEE;
  always @(posedge PCLK) begin
    if (init_mem) begin
      for (int i = 0; i < 64; i++) slave_mem[i] <= DW'(i * 37 + 5);
    end else if (PSEL && PENABLE && PWRITE) begin
      slave_mem[PADDR] <= PWDATA;
    end
  end

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  initial begin
    rnd_ready = 1'b1;
    forever begin
      @(posedge PCLK);
      #1 rnd_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, req, $time);
    end
  endtask

  function automatic rsp_t model(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rsp_t r;
    r.rdata = '0;
    r.err   = 1'b0;
    case (op)
      2'd0: ref_mem[a] = d;
      2'd1: r.rdata = ref_mem[a];
      2'd3: r.err = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  // Presents a command and returns 1 time unit after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic push);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    n = 0;
    @(negedge PCLK);
    while (!cmd_ready && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    else if (push) exp_q.push_back(model(op, a, d));
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge PCLK);
    while (!(cmd_ready && exp_q.size() == 0) && n < 3000) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", 0, 1);
    step();
  endtask

  // Scoreboard monitor: response handshake and hold-while-stalled.
  initial begin
    logic pv, pr, pe;
    logic [DW-1:0] pd;
    rsp_t e;
    pv = 0; pr = 0; pe = 0; pd = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESET_N) pv = 0;
      else begin
        if (pv && !pr) begin
          chk("rsp_valid_held", rsp_valid, 1);
          chk("rsp_rdata_stable", rsp_rdata, pd);
          chk("rsp_err_stable", rsp_err, pe);
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
          end
        end
        pv = rsp_valid; pr = rsp_ready; pd = rsp_rdata; pe = rsp_err;
      end
    end
  end

  // APB protocol monitor.
  initial begin
    logic ok, ps, pen, pw;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    ok = 0; ps = 0; pen = 0; pw = 0; pa = '0; pd = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESET_N) ok = 0;
      else begin
        if (ok) begin
          if (PENABLE) chk("apb_access_after_setup", {PSEL, ps, pen}, 3'b110);
          if (ps && !pen) chk("apb_single_setup", PENABLE, 1);
          if ((PSEL && PENABLE) || (!PSEL && !ps))
            chk("apb_bus_stable", {PADDR, PWRITE, PWDATA}, {pa, pw, pd});
        end
        ok = 1; ps = PSEL; pen = PENABLE; pw = PWRITE; pa = PADDR; pd = PWDATA;
      end
    end
  end

  // lock_ok must be LOCK delayed by SYNC cycles.
  initial forever begin
    @(negedge PCLK);
    lock_hist[cyc % 64] = LOCK;
    if (PRESET_N && (cyc - rel_cyc >= SYNC))
      chk("lock_ok_delay", lock_ok, lock_hist[(cyc - SYNC) % 64]);
  end

  initial begin
    int   cnt, got, seen;
    logic qual, lo;
    logic [1:0] op;
    int   r;
    logic lk [0:127];
    rsp_t tmp;
    errors = 0; checks = 0; cyc = 0; rel_cyc = 32'h4000_0000;
    PRESET_N = 1'b0; init_mem = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0;
    cmd_wdata = '0; LOCK = 1'b1; man_ready = 1'b1; rand_mode = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = DW'(i * 37 + 5);
    repeat (3) step();

    @(negedge PCLK);
    chk("reset_psel", PSEL, 0);
    chk("reset_penable", PENABLE, 0);
    chk("reset_apb_bus", {PWRITE, PADDR, PWDATA}, 0);
    chk("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_lock_ok", lock_ok, 0);
    step();
    PRESET_N = 1'b1; init_mem = 1'b0; rel_cyc = cyc;
    for (int i = 1; i <= SYNC; i++) begin
      step();
      chk("lock_ok_after_release", lock_ok, (i == SYNC) ? 1 : 0);
    end

    // Write 0x5C to 0x2A, cycle by cycle.
    issue(2'd0, 6'h2A, 8'h5C, 1'b1);
    @(negedge PCLK);
    chk("wr_setup_sel_en", {PSEL, PENABLE, PWRITE}, 3'b101);
    chk("wr_setup_addr", PADDR, 6'h2A);
    chk("wr_setup_data", PWDATA, 8'h5C);
    chk("wr_setup_cmd_ready", cmd_ready, 0);
    @(negedge PCLK);
    chk("wr_access_sel_en", {PSEL, PENABLE}, 2'b11);
    @(negedge PCLK);
    chk("wr_resp", {rsp_valid, rsp_err, rsp_rdata, PSEL}, {1'b1, 1'b0, 8'h00, 1'b0});
    @(negedge PCLK);
    chk("wr_done", {rsp_valid, cmd_ready}, 2'b01);
    chk("ccc_reg_written", slave_mem[6'h2A], 8'h5C);

    // Read 0x07 (holding 0xA3) under 5 cycles of response stall.
    step();
    issue(2'd0, 6'h07, 8'hA3, 1'b1);
    wait_idle();
    man_ready = 1'b0;
    issue(2'd1, 6'h07, 8'hFF, 1'b1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge PCLK);
      if (k == 1) chk("rd_setup", {PSEL, PENABLE, PWRITE, PADDR, PWDATA}, {3'b100, 6'h07, 8'hA3});
      if (k >= 3) chk("rd_stalled", {rsp_valid, rsp_rdata, cmd_ready}, {1'b1, 8'hA3, 1'b0});
    end
    step();
    man_ready = 1'b1;
    @(negedge PCLK);
    chk("rd_handshake_cycle", {rsp_valid, cmd_ready}, 2'b10);
    @(negedge PCLK);
    chk("rd_after_handshake", {rsp_valid, cmd_ready}, 2'b01);

    // Reserved op.
    step();
    issue(2'd3, 6'h11, 8'h22, 1'b1);
    @(negedge PCLK);
    chk("op11_resp", {rsp_valid, rsp_err, PSEL}, 3'b110);
    wait_idle();

    // Wait-lock with a 3-cycle dip after 10 high cycles.
    LOCK = 1'b0;
    repeat (4) step();
    issue(2'd2, 6'h00, 8'h00, 1'b1);
    cnt = 0; qual = 0; got = 0;
    for (int k = 1; k <= 100 && got == 0; k++) begin
      LOCK = (k <= 10) || (k >= 14);
      lk[k] = LOCK;
      @(negedge PCLK);
      if (qual) begin
        chk("lockwait_rsp", {rsp_valid, rsp_err}, 2'b10);
        got = k;
      end else begin
        chk("lockwait_no_early_rsp", rsp_valid, 0);
        lo = (k - SYNC >= 1) ? lk[k - SYNC] : 1'b0;
        cnt = lo ? cnt + 1 : 0;
        if (cnt == STABLE) qual = 1;
      end
      step();
    end
    if (got == 0) chk("lockwait_never_qualified", 0, 1);
    wait_idle();

    // Asynchronous reset during SETUP.
    issue(2'd1, 6'h05, 8'h00, 1'b1);
    chk("pre_reset_psel", PSEL, 1);
    #2 PRESET_N = 1'b0;
    #1;
    chk("async_reset_psel_penable", {PSEL, PENABLE}, 2'b00);
    chk("async_reset_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    step();
    PRESET_N = 1'b1; rel_cyc = cyc;
    repeat (4) begin
      @(negedge PCLK);
      chk("no_partial_rsp", rsp_valid, 0);
    end
    step();

    // Randomized traffic with random response back-pressure.
    rand_mode = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      op = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
      issue(op, AW'($urandom), DW'($urandom), 1'b1);
      repeat ($urandom_range(0, 3)) step();
    end
    wait_idle();
    rand_mode = 1'b0;

    LOCK = 1'b0;
    repeat (4) step();
`ifdef CCC_LOCK_TIMEOUT_EN
    issue(2'd2, 6'h00, 8'h00, 1'b0);
    tmp.rdata = '0; tmp.err = 1'b1;
    exp_q.push_back(tmp);
    got = 0;
    for (int k = 1; k <= 200 && got == 0; k++) begin
      @(negedge PCLK);
      if (rsp_valid) got = k;
    end
    chk("timeout_latency", got, TMO + 1);
    wait_idle();
    LOCK = 1'b1;
`else
    issue(2'd2, 6'h00, 8'h00, 1'b0);
    seen = 0;
    repeat (10000) begin
      @(negedge PCLK);
      if (rsp_valid) seen++;
    end
    chk("no_response_without_timeout", seen, 0);
    tmp.rdata = '0; tmp.err = 1'b0;
    exp_q.push_back(tmp);
    step();
    LOCK = 1'b1;
    wait_idle();
`endif

    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
